// File: rtl/rv32m_ext_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Handshake: the core holds i_EX_en until o_EX_ack, which is a one-cycle registered pulse.
//
// state | meaning
// IDLE  | waiting for i_EX_en; captures operands, flags and f3 when it is seen
// BUSY  | one iteration per edge, counter 0..XLEN-1; i_EX_en low aborts
// DONE  | o_EX_ack high for this single cycle; o_EX_res valid
module rv32m_ext_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_EX_en,
    input  logic [XLEN-1:0] i_EX_rs1,
    input  logic [XLEN-1:0] i_EX_rs2,
    input  logic [2:0]      i_EX_f3,
    output logic [XLEN-1:0] o_EX_res,
    output logic            o_EX_ack
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic            neg1_q, neg2_q;
    logic [XLEN-1:0] acc_hi, acc_lo, op_b;

    logic            capture, step, finish;

    // capture-time decode
    logic            sgn1, sgn2, neg1_in, neg2_in;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        sgn1     = (i_EX_f3 == 3'b001) || (i_EX_f3 == 3'b010) ||
                   (i_EX_f3 == 3'b100) || (i_EX_f3 == 3'b110);
        sgn2     = (i_EX_f3 == 3'b001) || (i_EX_f3 == 3'b100) || (i_EX_f3 == 3'b110);
        neg1_in  = sgn1 & i_EX_rs1[XLEN-1];
        neg2_in  = sgn2 & i_EX_rs2[XLEN-1];
        mag1     = neg1_in ? -i_EX_rs1 : i_EX_rs1;
        mag2     = neg2_in ? -i_EX_rs2 : i_EX_rs2;
        div_zero = i_EX_f3[2] && (i_EX_rs2 == '0);
        div_ovf  = i_EX_f3[2] && !i_EX_f3[0] && (i_EX_rs1 == MIN_INT) && (i_EX_rs2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = i_EX_f3[1] ? i_EX_rs1 : '1;
        else
            special_res = i_EX_f3[1] ? '0 : MIN_INT;
    end

    // one iteration of either datapath; acc_lo holds multiplier or dividend/quotient
    logic [XLEN:0]   mul_add, mul_sum, rem_sh, rem_diff;
    logic [XLEN-1:0] step_hi, step_lo;

    always_comb begin
        mul_add  = acc_lo[0] ? {1'b0, op_b} : '0;
        mul_sum  = {1'b0, acc_hi} + mul_add;
        rem_sh   = {acc_hi, acc_lo[XLEN-1]};
        rem_diff = rem_sh - {1'b0, op_b};
        if (f3_q[2]) begin
            step_hi = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], ~rem_diff[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_res;

    always_comb begin
        prod   = {step_hi, step_lo};
        prod_s = (neg1_q ^ neg2_q) ? -prod : prod;
        quot_s = (neg1_q ^ neg2_q) ? -step_lo : step_lo;
        rem_s  = neg1_q ? -step_hi : step_hi;
        case (f3_q)
            3'b000:                 final_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quot_s;
            default:                final_res = rem_s;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (i_EX_en) begin
                    capture   = 1'b1;
                    state_nxt = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!i_EX_en) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(XLEN-1)) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt      <= '0;
            f3_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            op_b     <= '0;
            o_EX_res <= '0;
            o_EX_ack <= 1'b0;
        end else begin
            o_EX_ack <= (capture && special) || finish;
            if (capture) begin
                cnt    <= '0;
                f3_q   <= i_EX_f3;
                neg1_q <= neg1_in;
                neg2_q <= neg2_in;
                acc_hi <= '0;
                acc_lo <= mag1;
                op_b   <= mag2;
                if (special)
                    o_EX_res <= special_res;
            end else if (step) begin
                cnt    <= cnt + 1'b1;
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                if (finish)
                    o_EX_res <= final_res;
            end
        end
    end

endmodule

// File: doc/rv32m_ext_unit.md
Name: rv32m_ext_unit

Overview:
- External RV32M multiply/divide unit; sits directly downstream of the hart's o_EX_* port group and returns i_EX_res/i_EX_ack.
- Iterative: one shift-add (MUL*) or restoring-subtract (DIV*/REM*) step per cycle over XLEN cycles.
- The single-cycle datapath stalls while o_EX_en is high. It retires the M instruction in the cycle ack is high.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported. Counter width is clog2(XLEN).

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_EX_en  input  1  operation request; held high by the core until ack
- i_EX_rs1  input  XLEN  operand 1 (dividend / multiplicand)
- i_EX_rs2  input  XLEN  operand 2 (divisor / multiplier)
- i_EX_f3  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- o_EX_res  output  XLEN  result. Registered; meaningful only while o_EX_ack=1.
- o_EX_ack  output  1  single-cycle completion pulse

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Clock is i_clk, reset is i_rst.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE, o_EX_res=0, o_EX_ack=0, counter=0, internal accumulators=0.
  - An in-flight operation is discarded; no ack is produced for it.
- States: IDLE, BUSY, DONE.
- IDLE, with i_EX_en=1 sampled at an edge:
  - Latch f3.
  - Latch sign flags: rs1 is signed for MULH, MULHSU, DIV, REM; rs2 is signed for MULH, DIV, REM.
  - Latch operand magnitudes (two's-complement absolute value when signed and negative). abs(0x80000000) = 0x80000000 as unsigned.
  - Clear counter.
  - Next state: DONE if a special case applies, else BUSY.
- Special cases, resolved at capture:
  - Divide by zero (rs2=0, f3[2]=1): DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
  - The result register is loaded and ack is high in the cycle after capture (latency 1).
- BUSY:
  - One iteration per edge; counter increments 0..XLEN-1.
  - MUL*: 2*XLEN-bit unsigned shift-add product of the magnitudes.
  - DIV*: restoring division; one quotient bit per cycle, MSB first, with an XLEN+1-bit partial remainder.
  - On the edge where counter=XLEN-1: apply sign correction, load o_EX_res, set o_EX_ack=1, go to DONE.
- Sign correction:
  - Product negated if the operand signs differ (signed operands only).
  - Quotient negated if s1^s2 (DIV).
  - Remainder takes the sign of rs1 (REM).
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Latency, counting the capture edge as cycle 0: normal ops have ack high in cycle XLEN+1 (33).
- DONE:
  - o_EX_ack=1 for exactly one cycle; o_EX_res holds the result.
  - Next edge: ack=0, state=IDLE. o_EX_res retains its value until the next load.
- Back-to-back requests: the core advances on ack, so i_EX_en may remain high. A high i_EX_en in the IDLE cycle following DONE starts a new operation with the operands present then. Minimum gap between acks is therefore 2 cycles for special cases and 34 for normal ops.
- Abort: i_EX_en=0 sampled in BUSY → IDLE next edge, no ack, o_EX_res unchanged.
- i_EX_en=0 during DONE is ignored; the ack still completes.
- Operand or f3 changes while BUSY are ignored (latched values are used).
- o_EX_ack is never high in two consecutive cycles.
- No combinational path from inputs to outputs.

Test Plan:
- MUL 7*(-3) (rs1=7, rs2=0xFFFFFFFD, f3=000) → ack in cycle 33, res=0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE; MULHSU rs1=-1, rs2=2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each has ack in cycle 33.
- Divide by zero DIVU 5/0 → res 0xFFFFFFFF, ack in cycle 1. Overflow DIV 0x80000000/-1 → 0x80000000; REM of the same → 0.
- i_EX_en held high across two requests (MUL 3*4, then DIV 12/4) → two single-cycle acks, res 12 then 3. No extra ack is produced and the second op starts in the IDLE cycle after the first ack.
- Abort and reset:
  - Drop i_EX_en in BUSY cycle 10 → no ack, IDLE next cycle, o_EX_res unchanged.
  - Assert i_rst asynchronously mid-BUSY → o_EX_ack=0 and o_EX_res=0 immediately.
  - A subsequent MUL 2*2 → 4.
- Operand instability: change rs1/rs2/f3 during BUSY → result reflects the values latched at capture.
